// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two requesters share one single-cycle dmem through a 3-cycle IDLE/ACCESS/RESP transaction.
// Tie-break is fixed port-0 priority, or round robin when DMEM_ARB_ROUND_ROBIN_EN is defined.
module dmem_arbiter #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        busy,
    output logic [1:0]  dbgState
);
    // Handshake: a requester raises reqN with weN/addrN/wdN and keeps req high until
    // the single-cycle ackN pulse; errN is meaningful only while ackN is high.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    logic [1:0]  state;
    logic        winId;
    logic        latWe;
    logic        latFault;
    logic [31:0] latAddr;
    logic [31:0] latWd;

    logic        anyReq;
    logic        grant1;
    logic        pickWe;
    logic        pickFault;
    logic [31:0] pickAddr;
    logic [31:0] pickWd;
    logic        inAccess;
    logic        inResp;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic lastGrant;

    // On a tie the port that was not granted last wins.
    assign grant1 = req1 & (~req0 | ~lastGrant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGrant <= 1'b1;
        end else if (state == IDLE && anyReq) begin
            lastGrant <= grant1;
        end
    end
`else
    assign grant1 = req1 & ~req0;
`endif

    assign anyReq    = req0 | req1;
    assign pickWe    = grant1 ? we1   : we0;
    assign pickAddr  = grant1 ? addr1 : addr0;
    assign pickWd    = grant1 ? wd1   : wd0;
    assign pickFault = (pickAddr[1:0] != 2'b00) || (pickAddr >= ADDR_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            winId    <= 1'b0;
            latWe    <= 1'b0;
            latFault <= 1'b0;
            latAddr  <= '0;
            latWd    <= '0;
            rd0      <= '0;
            rd1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        state    <= ACCESS;
                        winId    <= grant1;
                        latWe    <= pickWe;
                        latFault <= pickFault;
                        latAddr  <= pickAddr;
                        latWd    <= pickWd;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    // A faulted read returns zero rather than whatever dmem drives.
                    if (!latWe) begin
                        if (winId) begin
                            rd1 <= latFault ? '0 : mem_rd;
                        end else begin
                            rd0 <= latFault ? '0 : mem_rd;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign inAccess = (state == ACCESS);
    assign inResp   = (state == RESP);

    assign mem_we   = inAccess & latWe & ~latFault;
    assign mem_addr = inAccess ? latAddr : '0;
    assign mem_wd   = inAccess ? latWd   : '0;

    assign ack0     = inResp & ~winId;
    assign ack1     = inResp &  winId;
    assign err0     = ack0 & latFault;
    assign err1     = ack1 & latFault;
    assign busy     = inAccess | inResp;
    assign dbgState = state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random two-port traffic, checked every cycle
// against a transaction-level model of timing, arbitration and memory contents.
module tb_dmem_arbiter;
    localparam int MEM_WORDS = 64;
    localparam int AW = $clog2(MEM_WORDS);

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        busy;
    logic [1:0]  dbgState;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rd0(rd0), .rd1(rd1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy), .dbgState(dbgState)
    );

    // attached single-cycle dmem
    bit [31:0] dmem [MEM_WORDS];
    assign mem_rd = dmem[mem_addr[AW+1:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[AW+1:2]] <= mem_wd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    bit [31:0]   refMem [MEM_WORDS];
    bit          active [2];
    bit          pWe [2];
    logic [31:0] pAddr [2];
    logic [31:0] pWd [2];
    int          repeatLeft [2];
    bit          randomOn;
    logic [31:0] expRd [2];
    bit          curValid;
    int          curPort;
    bit          curWe, curFault;
    logic [31:0] curAddr, curWd;
    int          curAcc;
    int          nextSample;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    int          lastGrant;
`endif
    logic [31:0] expQ [$];
    int          grantLog [$];
    int          nChecks = 0;
    int          nFail = 0;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_fault(logic [31:0] a);
        return (a % 4 != 0) || (a >= MEM_WORDS * 4);
    endfunction

    function automatic logic [31:0] gen_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, MEM_WORDS - 1) * 4);
        else if (r == 7) return 32'($urandom_range(0, MEM_WORDS * 4 - 1)) | 32'd1;
        else if (r == 8) return 32'(MEM_WORDS * 4 + $urandom_range(0, 15) * 4);
        else             return $urandom();
    endfunction

    // ---------------- driver tasks ----------------
    task automatic new_cmd(input int p);
        active[p] = 1'b1;
        pWe[p]    = 1'($urandom_range(0, 1));
        pAddr[p]  = gen_addr();
        pWd[p]    = $urandom();
    endtask

    task automatic set_cmd(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        active[p] = 1'b1;
        pWe[p]    = w;
        pAddr[p]  = a;
        pWd[p]    = d;
    endtask

    task automatic drive_ports();
        req0 = active[0]; we0 = pWe[0]; addr0 = pAddr[0]; wd0 = pWd[0];
        req1 = active[1]; we1 = pWe[1]; addr1 = pAddr[1]; wd1 = pWd[1];
    endtask

    task automatic check_outputs(input bit inAcc, input bit inResp);
        check("busy",     32'(busy),   32'(inAcc || inResp));
        check("mem_we",   32'(mem_we), 32'(inAcc && curWe && !curFault));
        check("mem_addr", mem_addr,    inAcc ? curAddr : 32'd0);
        check("mem_wd",   mem_wd,      inAcc ? curWd : 32'd0);
        check("ack0",     32'(ack0),   32'(inResp && curPort == 0));
        check("ack1",     32'(ack1),   32'(inResp && curPort == 1));
        check("err0",     32'(err0),   32'(inResp && curPort == 0 && curFault));
        check("err1",     32'(err1),   32'(inResp && curPort == 1 && curFault));
        check("rd0",      rd0,         expRd[0]);
        check("rd1",      rd1,         expRd[1]);
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step();
        bit inAcc, inResp;
        int obs, p, w;
        inAcc  = curValid && (cyc == curAcc);
        inResp = curValid && (cyc == curAcc + 1);
        if (inResp) begin
            if (!curWe) expRd[curPort] = curFault ? 32'd0 : refMem[curAddr / 4];
            else if (!curFault) refMem[curAddr / 4] = curWd;
        end
        check_outputs(inAcc, inResp);
        if (inResp) begin
            obs = ack1 ? 1 : (ack0 ? 0 : -1);
            if (expQ.size() > 0) check("ack_port", 32'(obs), expQ.pop_front());
            grantLog.push_back(obs);
            curValid = 1'b0;
            p = curPort;
            if (repeatLeft[p] > 0) begin
                repeatLeft[p]--;
                new_cmd(p);
            end else if (randomOn && $urandom_range(0, 3) == 0) begin
                new_cmd(p);
            end else begin
                active[p] = 1'b0;
            end
        end
        // inputs change after capture; the transaction in flight must not notice
        if (inAcc && randomOn) begin
            pWe[curPort]   = ~pWe[curPort];
            pAddr[curPort] = $urandom();
            pWd[curPort]   = $urandom();
        end
        if (randomOn) begin
            for (int q = 0; q < 2; q++)
                if (!active[q] && $urandom_range(0, 2) == 0) new_cmd(q);
        end
        drive_ports();
        if (!curValid && (cyc + 1 >= nextSample) && (active[0] || active[1])) begin
            if (active[0] && active[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                w = (lastGrant == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else begin
                w = active[1] ? 1 : 0;
            end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            lastGrant = w;
`endif
            curValid   = 1'b1;
            curPort    = w;
            curWe      = pWe[w];
            curAddr    = pAddr[w];
            curWd      = pWd[w];
            curFault   = is_fault(pAddr[w]);
            curAcc     = cyc + 1;
            nextSample = cyc + 4;
            expQ.push_back(32'(w));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic model_reset();
        curValid   = 1'b0;
        nextSample = 0;
        expRd[0]   = 32'd0;
        expRd[1]   = 32'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        lastGrant  = 1;
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0;
        randomOn = 1'b0;
        for (int p = 0; p < 2; p++) begin
            active[p] = 1'b0; pWe[p] = 1'b0; pAddr[p] = '0; pWd[p] = '0; repeatLeft[p] = 0;
        end
        curPort = 0; curWe = 1'b0; curFault = 1'b0; curAddr = '0; curWd = '0; curAcc = 0;
        model_reset();
        drive_ports();
        repeat (3) @(negedge clk);
        check_outputs(1'b0, 1'b0);
        reset = 1'b1;

        // port 0 write then port 1 read-back of the same word
        set_cmd(0, 1'b1, 32'h64, 32'hA);
        run(4);
        check("wr_commit", dmem[25], 32'hA);
        set_cmd(1, 1'b0, 32'h64, 32'h0);
        run(4);
        check("rd_back", rd1, 32'hA);
        check("rd0_kept", rd0, 32'h0);

        // misaligned write and out-of-range read both fault
        set_cmd(0, 1'b1, 32'h66, 32'h55);
        run(4);
        check("fault_no_wr", dmem[25], 32'hA);
        set_cmd(1, 1'b0, 32'h100, 32'h0);
        run(4);
        check("fault_rd_zero", rd1, 32'h0);

        // both ports hold req for four transactions each
        grantLog.delete();
        repeatLeft[0] = 3;
        repeatLeft[1] = 3;
        new_cmd(0);
        new_cmd(1);
        run(30);
        begin
            int expOrder [4];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            expOrder = '{0, 1, 0, 1};
`else
            expOrder = '{0, 0, 0, 0};
`endif
            check("tie_count", 32'(grantLog.size()), 32'd8);
            for (int i = 0; i < 4; i++)
                if (i < grantLog.size()) check("tie_order", 32'(grantLog[i]), 32'(expOrder[i]));
        end

        // reset lands during the ACCESS cycle of a write
        set_cmd(0, 1'b1, 32'h10, 32'hDEADBEEF);
        step();
        check("pre_rst_we", 32'(mem_we), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        if (expQ.size() > 0) void'(expQ.pop_back());
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b0);
        end
        check("rst_no_write", dmem[4], refMem[4]);
        reset = 1'b1;
        run(5);
        check("rst_retry", dmem[4], 32'hDEADBEEF);

        // random two-port traffic
        randomOn = 1'b1;
        run(1500);
        randomOn = 1'b0;
        run(10);
        check("drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
